div4_seq: RTL

Sequential 4-bit unsigned divider: the inverse operation of the team's 4-bit ripple adder, built from a 5-bit trial subtraction and iterated one quotient bit per clock (restoring algorithm). Sits beside the adder in the datapath as a multi-cycle functional unit with a start/done handshake. It produces quotient, remainder and a divide-by-zero flag.

---
 rtl/div4_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider with a start/done handshake.
// Computes one quotient bit per clock, MSB first; B==0 short-circuits to FIN.
module div4_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       DivZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       dz_q, dz_d;
  logic       busy_q, done_q;

  // Datapath for the current iteration: bit index i = 3 - counter.
  logic [1:0] bit_idx;
  logic [3:0] rem_sh;
  logic [4:0] diff;
  logic       qbit;
  logic [3:0] rem_nx;
  logic [3:0] quo_nx;

  always_comb begin
    bit_idx = 2'd3 - cnt_q;
    rem_sh  = {rem_q[2:0], dvd_q[bit_idx]};
    diff    = {1'b0, rem_sh} - {1'b0, dvs_q};
    qbit    = ~diff[4];
    rem_nx  = qbit ? diff[3:0] : rem_sh;
    quo_nx  = quo_q;
    quo_nx[bit_idx] = qbit;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = A;
          dvs_d = B;
          rem_d = 4'd0;
          quo_d = 4'd0;
          cnt_d = 2'd0;
          if (B == 4'd0) begin
            state_d = FIN;
            q_d     = 4'hF;
            r_d     = A;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = FIN;
          q_d     = quo_nx;
          r_d     = rem_nx;
          dz_d    = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so outputs stay flop-driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      dvd_q   <= 4'd0;
      dvs_q   <= 4'd0;
      rem_q   <= 4'd0;
      quo_q   <= 4'd0;
      q_q     <= 4'd0;
      r_q     <= 4'd0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FIN);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Q       = q_q;
  assign R       = r_q;
  assign DivZero = dz_q;

endmodule
